interrupt_controller: RTL and testbench

//  Sequences the two program-counter interrupts. Synchronises and edge-detects INT0/INT1 requests, then arbitrates them.

---
 rtl/interrupt_controller_pkg.sv | 33 +++
 rtl/interrupt_controller_int_sync_edge.sv | 46 ++++
 rtl/interrupt_controller.sv | 144 ++++++++++++++
 tb/tb_interrupt_controller.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller_pkg
// Description : Shared constants for the two-level interrupt controller:
//               program-counter next-address select codes, interrupt
//               vector addresses and controller state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package interrupt_controller_pkg;

    // Next-address select presented to the program counter
    typedef enum logic [2:0] {
        PC_NEXT  = 3'b000,
        PC_INTV0 = 3'b001,
        PC_INTV1 = 3'b010,
        PC_INTR0 = 3'b011,
        PC_INTR1 = 3'b100
    } pc_next_e;

    // Interrupt vector addresses loaded by the program counter on PC_INTVn
    localparam logic [7:0] C_INTV0_ADDR = 8'h04;
    localparam logic [7:0] C_INTV1_ADDR = 8'h08;

    // In-service nesting state
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_IN1       = 2'b01,
        ST_IN0       = 2'b10,
        ST_IN0_OVER1 = 2'b11
    } ic_state_e;

endpackage
`default_nettype wire

// File: rtl/interrupt_controller_int_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : int_sync_edge
// Description : Multi-flop synchroniser for an asynchronous interrupt request
//               followed by a rising-edge detector. A level that is already
//               high when reset releases produces one edge, because the
//               edge register resets low.
// Revision    : 1.0 - initial release
// ============================================================================
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req,
    output logic o_edge
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   w_level;

    assign w_level = r_sync[SYNC_STAGES-1];

    // Shift the raw request through the synchroniser chain
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_req};
        end
    end

    // Remember the previous synchronised level for edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_edge = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Captures INT0/INT1 request edges, arbitrates them against the
//               global enable and current nesting state, and on each
//               qualified fetch (FETCH & PC_ENX) drives the program counter's
//               next-address select and return-address load strobes.
//               INT0 may preempt INT1; INT1 never preempts, INT0 never
//               re-enters.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_fetch,
    input  logic       i_pc_enx,
    input  logic       i_int0_req,
    input  logic       i_int1_req,
    input  logic       i_ei_x,
    input  logic       i_di_x,
    input  logic       i_reti_x,
    output logic [2:0] o_pc_nextx,
    output logic       o_pc_ld_int0x,
    output logic       o_pc_ld_int1x,
    output logic       o_int_en,
    output logic       o_int0_pend,
    output logic       o_int1_pend,
    output logic       o_int0_active,
    output logic       o_int1_active
);

    ic_state_e r_state;
    ic_state_e w_state_nxt;
    pc_next_e  w_pc_next;
    logic      r_int_en;
    logic      r_pend0;
    logic      r_pend1;
    logic      w_edge0;
    logic      w_edge1;
    logic      w_qfetch;
    logic      w_take0;
    logic      w_take1;

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_int0_req),
        .o_edge  (w_edge0)
    );

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_req   (i_int1_req),
        .o_edge  (w_edge1)
    );

    assign w_qfetch = i_fetch & i_pc_enx;

    // Arbitration: RETI has absolute priority on its fetch, then INT0, then INT1
    always_comb begin
        w_pc_next   = PC_NEXT;
        w_take0     = 1'b0;
        w_take1     = 1'b0;
        w_state_nxt = r_state;
        if (w_qfetch) begin
            if (i_reti_x) begin
                case (r_state)
                    ST_IN0: begin
                        w_pc_next   = PC_INTR0;
                        w_state_nxt = ST_IDLE;
                    end
                    ST_IN0_OVER1: begin
                        w_pc_next   = PC_INTR0;
                        w_state_nxt = ST_IN1;
                    end
                    ST_IN1: begin
                        w_pc_next   = PC_INTR1;
                        w_state_nxt = ST_IDLE;
                    end
                    ST_IDLE: begin
                        w_pc_next   = PC_NEXT;
                        w_state_nxt = ST_IDLE;
                    end
                endcase
            end else if (r_int_en && r_pend0 &&
                         (r_state == ST_IDLE || r_state == ST_IN1)) begin
                w_pc_next   = PC_INTV0;
                w_take0     = 1'b1;
                w_state_nxt = (r_state == ST_IN1) ? ST_IN0_OVER1 : ST_IN0;
            end else if (r_int_en && r_pend1 && r_state == ST_IDLE) begin
                w_pc_next   = PC_INTV1;
                w_take1     = 1'b1;
                w_state_nxt = ST_IN1;
            end
        end
    end

    // Global enable; disable wins when both strobes arrive together
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int_en <= 1'b0;
        end else if (i_di_x) begin
            r_int_en <= 1'b0;
        end else if (i_ei_x) begin
            r_int_en <= 1'b1;
        end
    end

    // Pending flags: a fresh edge overrides a take in the same cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend0 <= 1'b0;
            r_pend1 <= 1'b0;
        end else begin
            r_pend0 <= w_edge0 | (r_pend0 & ~w_take0);
            r_pend1 <= w_edge1 | (r_pend1 & ~w_take1);
        end
    end

    // In-service nesting state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign o_pc_nextx    = w_pc_next;
    assign o_pc_ld_int0x = w_take0;
    assign o_pc_ld_int1x = w_take1;
    assign o_int_en      = r_int_en;
    assign o_int0_pend   = r_pend0;
    assign o_int1_pend   = r_pend1;
    assign o_int0_active = (r_state == ST_IN0) || (r_state == ST_IN0_OVER1);
    assign o_int1_active = (r_state == ST_IN1) || (r_state == ST_IN0_OVER1);

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed-vector scoreboard bench for interrupt_controller.
//               Stimulus pushes hand-computed expected outputs for the
//               current cycle; the monitor pops and compares them on the
//               falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic       clk;
    logic       rst_n;
    logic       fetch, pc_enx, int0_req, int1_req, ei_x, di_x, reti_x;
    logic [2:0] pc_nextx;
    logic       ld0, ld1, int_en, pend0, pend1, act0, act1;

    typedef struct {
        string      name;
        logic [9:0] v;
    } exp_t;

    exp_t q[$];
    int   n_cmp;
    int   n_bad;

    interrupt_controller #(.SYNC_STAGES(2)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fetch       (fetch),
        .i_pc_enx      (pc_enx),
        .i_int0_req    (int0_req),
        .i_int1_req    (int1_req),
        .i_ei_x        (ei_x),
        .i_di_x        (di_x),
        .i_reti_x      (reti_x),
        .o_pc_nextx    (pc_nextx),
        .o_pc_ld_int0x (ld0),
        .o_pc_ld_int1x (ld1),
        .o_int_en      (int_en),
        .o_int0_pend   (pend0),
        .o_int1_pend   (pend1),
        .o_int0_active (act0),
        .o_int1_active (act1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge and apply control strobes
    task automatic step(input logic f, input logic p, input logic ei,
                        input logic di, input logic rt);
        @(posedge clk);
        #1;
        fetch  = f;
        pc_enx = p;
        ei_x   = ei;
        di_x   = di;
        reti_x = rt;
    endtask

    // Queue the expected output vector for the current cycle
    task automatic expect_out(input string n, input logic [2:0] nx,
                              input logic l0, input logic l1, input logic en,
                              input logic p0, input logic p1,
                              input logic a0, input logic a1);
        exp_t e;
        e.name = n;
        e.v    = {nx, l0, l1, en, p0, p1, a0, a1};
        q.push_back(e);
    endtask

    // Monitor: compare every queued expectation mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [9:0] act;
            e   = q.pop_front();
            act = {pc_nextx, ld0, ld1, int_en, pend0, pend1, act0, act1};
            n_cmp++;
            if (act !== e.v) begin
                n_bad++;
                $display("FAIL %s: got nx=%b ld0/ld1=%b%b en=%b p0/p1=%b%b a0/a1=%b%b, want nx=%b ld0/ld1=%b%b en=%b p0/p1=%b%b a0/a1=%b%b",
                         e.name, act[9:7], act[6], act[5], act[4], act[3], act[2], act[1], act[0],
                         e.v[9:7], e.v[6], e.v[5], e.v[4], e.v[3], e.v[2], e.v[1], e.v[0]);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        fetch = 0; pc_enx = 0; ei_x = 0; di_x = 0; reti_x = 0;
        int0_req = 0; int1_req = 0;

        step(1, 1, 0, 0, 1);
        expect_out("reset_state", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // INT1 one-clock pulse with interrupts disabled
        step(0, 0, 0, 0, 0); int1_req = 1;
        expect_out("int1_pulse_c0", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); int1_req = 0;
        step(0, 0, 0, 0, 0);
        expect_out("int1_pend_not_yet", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("int1_pend_disabled_fetch", 3'b000, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        expect_out("ei_not_yet", 3'b000, 0, 0, 0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_int1", 3'b010, 0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("in_int1", 3'b000, 0, 0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 1);
        expect_out("reti_int1", 3'b100, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_out("idle_after_reti1", 3'b000, 0, 0, 1, 0, 0, 0, 0);

        // INT0 and INT1 rise together, held high
        step(0, 0, 0, 0, 0); int0_req = 1; int1_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("both_pend_not_yet", 3'b000, 0, 0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_int0_first", 3'b001, 1, 0, 1, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("in_int0_int1_pend", 3'b000, 0, 0, 1, 0, 1, 1, 0);
        step(1, 1, 0, 0, 1);
        expect_out("reti_int0", 3'b011, 0, 0, 1, 0, 1, 1, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_int1_after", 3'b010, 0, 1, 1, 0, 1, 0, 0);

        // Nesting: INT0 preempts INT1
        step(0, 0, 0, 0, 0); int0_req = 0;
        expect_out("in_int1_no_reedge", 3'b000, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0); int0_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("nest_pend_not_yet", 3'b000, 0, 0, 1, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        expect_out("preempt_int0", 3'b001, 1, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_out("in0_over1", 3'b000, 0, 0, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1);
        expect_out("reti_over1", 3'b011, 0, 0, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1);
        expect_out("reti_back_in1", 3'b100, 0, 0, 1, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_out("idle_after_nest", 3'b000, 0, 0, 1, 0, 0, 0, 0);

        // RETI with INT0 pending while INT0 in service
        step(0, 0, 0, 0, 0); int0_req = 0;
        step(0, 0, 0, 0, 0); int0_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_int0_again", 3'b001, 1, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0); int0_req = 0;
        step(0, 0, 0, 0, 0); int0_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("in0_no_reentry", 3'b000, 0, 0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1);
        expect_out("reti_holds_pend0", 3'b011, 0, 0, 1, 1, 0, 1, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_pend0_after_reti", 3'b001, 1, 0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        expect_out("reti_int0_b", 3'b011, 0, 0, 1, 0, 0, 1, 0);
        step(1, 1, 0, 0, 1);
        expect_out("reti_in_idle", 3'b000, 0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("idle_unchanged", 3'b000, 0, 0, 1, 0, 0, 0, 0);

        // Unqualified fetch, then EI/DI together
        step(0, 0, 0, 0, 0); int1_req = 0;
        step(0, 0, 0, 0, 0); int1_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        expect_out("fetch_no_pcen", 3'b000, 0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 1, 1, 0);
        expect_out("pcen_no_fetch", 3'b000, 0, 0, 1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("di_wins", 3'b000, 0, 0, 0, 0, 1, 0, 0);

        // Build IN0_OVER1, then reset asynchronously with INT0 held high
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_int1_pre_reset", 3'b010, 0, 1, 1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0); int0_req = 0; int1_req = 0;
        step(0, 0, 0, 0, 0); int0_req = 1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("preempt_pre_reset", 3'b001, 1, 0, 1, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        expect_out("over1_pre_reset", 3'b000, 0, 0, 1, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0); rst_n = 1'b0;
        expect_out("async_reset_immediate", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0); rst_n = 1'b1;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("post_reset_not_yet", 3'b000, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("post_reset_pend0", 3'b000, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        expect_out("take_post_reset", 3'b001, 1, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("post_take_once", 3'b000, 0, 0, 1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        expect_out("held_level_one_edge", 3'b000, 0, 0, 1, 0, 0, 1, 0);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
